// File: rtl/spi_pkg.sv
// spi_pkg: shared types, widths and baud helper for the SPI transfer sequencer.
// Holds the sequencer state enum, the latched configuration payload and the
// half-period computation shared by the baud generator.
package spi_pkg;

    localparam int unsigned EDGES_PER_XFER = 16;
    localparam int unsigned HALF_W         = 11;
    localparam int unsigned EDGE_W         = 5;
    localparam int unsigned BAUD_W         = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } spi_state_e;

    // Mode and baud settings captured when a transfer is accepted
    typedef struct packed {
        logic              cpol;
        logic              cpha;
        logic [BAUD_W-1:0] sppr;
        logic [BAUD_W-1:0] spr;
    } spi_cfg_t;

    // SCLK half period in PCLK cycles: (sppr+1) << spr, range 1..1024
    function automatic logic [HALF_W-1:0] half_period(input logic [BAUD_W-1:0] sppr,
                                                      input logic [BAUD_W-1:0] spr);
        return (HALF_W'(sppr) + HALF_W'(1)) << spr;
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// spi_xfer_ctrl_if: control/config and sequencing signals between the APB
// register block (master) and the transfer sequencer (slave).
//   spe_i, start_i, cpol_i, cpha_i, sppr_i, spr_i : configuration and request
//   sclk_o, ss_o                                  : serial clock, slave select
//   send_data_o, recieve_data_o                   : shifter load / RX byte valid
//   mosi_send_sclk*_o, miso_recieve_sclk*_o       : per-edge shift strobes
//   busy_o, done_o                                : status
interface spi_xfer_ctrl_if;
    import spi_pkg::*;

    logic              spe_i;
    logic              start_i;
    logic              cpol_i;
    logic              cpha_i;
    logic [BAUD_W-1:0] sppr_i;
    logic [BAUD_W-1:0] spr_i;

    logic              sclk_o;
    logic              ss_o;
    logic              send_data_o;
    logic              recieve_data_o;
    logic              mosi_send_sclk_o;
    logic              mosi_send_sclk0_o;
    logic              miso_recieve_sclk_o;
    logic              miso_recieve_sclk0_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output spe_i, start_i, cpol_i, cpha_i, sppr_i, spr_i,
        input  sclk_o, ss_o, send_data_o, recieve_data_o,
               mosi_send_sclk_o, mosi_send_sclk0_o,
               miso_recieve_sclk_o, miso_recieve_sclk0_o,
               busy_o, done_o
    );

    modport slave (
        input  spe_i, start_i, cpol_i, cpha_i, sppr_i, spr_i,
        output sclk_o, ss_o, send_data_o, recieve_data_o,
               mosi_send_sclk_o, mosi_send_sclk0_o,
               miso_recieve_sclk_o, miso_recieve_sclk0_o,
               busy_o, done_o
    );

endinterface

// File: rtl/spi_baud_gen.sv
// spi_baud_gen: SCLK half-period counter.
//   PCLK, PRESET : clock, synchronous active-high reset
//   run          : count enable; counter held at zero while low
//   sppr, spr    : latched baud preselect / select
//   half_tick_c  : high in the last cycle of each half period (combinational)
module spi_baud_gen
    import spi_pkg::*;
(
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              run,
    input  logic [BAUD_W-1:0] sppr,
    input  logic [BAUD_W-1:0] spr,
    output logic              half_tick_c
);

    logic [HALF_W-1:0] half_cnt;
    logic [HALF_W-1:0] half_last;

    assign half_last   = half_period(sppr, spr) - HALF_W'(1);
    assign half_tick_c = run && (half_cnt == half_last);

    // Counts 0..H-1 and wraps; cleared whenever the sequencer is not shifting
    always_ff @(posedge PCLK) begin
        if (PRESET || !run || half_tick_c) begin
            half_cnt <= '0;
        end else begin
            half_cnt <= half_cnt + HALF_W'(1);
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: 8-bit full-duplex SPI transfer sequencer.
//   PCLK, PRESET : clock, synchronous active-high reset
//   bus (slave)  : spe/start/mode/baud inputs; SCLK, SS, shifter load and
//                  capture, per-edge MOSI/MISO strobes, busy and done outputs
// One start request runs LOAD, a SHIFT phase of 16 SCLK edges plus lead-in and
// tail, and a one-cycle DONE. All outputs are registered.
module spi_xfer_ctrl
    import spi_pkg::*;
(
    input  logic           PCLK,
    input  logic           PRESET,
    spi_xfer_ctrl_if.slave bus
);

    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(EDGES_PER_XFER);
    localparam logic [EDGE_W-1:0] TAIL_END  = EDGE_W'(EDGES_PER_XFER + 1);

    spi_state_e        state;
    spi_cfg_t          cfg_q;
    logic [EDGE_W-1:0] edge_cnt;
    logic              edge_q;

    logic sclk_q, ss_q, send_q, rdv_q, busy_q, done_q;
    logic mosi_q, mosi0_q, miso_q, miso0_q;

    logic              run_c;
    logic              half_tick_c;
    logic [EDGE_W-1:0] next_edge_c;
    logic              lead_c;
    logic              send_hit_c;
    logic              recv_hit_c;
    logic              pair_sclk_c;

    assign run_c = (state == SHIFT) && bus.spe_i;

    spi_baud_gen u_baud (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .run         (run_c),
        .sppr        (cfg_q.sppr),
        .spr         (cfg_q.spr),
        .half_tick_c (half_tick_c)
    );

    // Decode of the edge that the current half-period tick announces.
    // Odd edges are leading, even edges trailing; with CPHA=0 the first MOSI
    // shift happens at the lead-in, so edge 16 carries no send strobe.
    assign next_edge_c = edge_cnt + EDGE_W'(1);
    assign lead_c      = next_edge_c[0];
    assign send_hit_c  = (next_edge_c <= LAST_EDGE) &&
                         (cfg_q.cpha ? lead_c : (!lead_c && (next_edge_c != LAST_EDGE)));
    assign recv_hit_c  = (next_edge_c <= LAST_EDGE) && (cfg_q.cpha ? !lead_c : lead_c);
    assign pair_sclk_c = (cfg_q.cpol == cfg_q.cpha);

    // Sequencer FSM. A tick registers edge_q plus the strobes, so both are high
    // in the cycle whose closing PCLK edge flips SCLK.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= IDLE;
            cfg_q    <= '0;
            edge_cnt <= '0;
            edge_q   <= 1'b0;
            sclk_q   <= 1'b0;
            ss_q     <= 1'b1;
            send_q   <= 1'b0;
            rdv_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mosi_q   <= 1'b0;
            mosi0_q  <= 1'b0;
            miso_q   <= 1'b0;
            miso0_q  <= 1'b0;
        end else begin
            send_q  <= 1'b0;
            rdv_q   <= 1'b0;
            done_q  <= 1'b0;
            edge_q  <= 1'b0;
            mosi_q  <= 1'b0;
            mosi0_q <= 1'b0;
            miso_q  <= 1'b0;
            miso0_q <= 1'b0;

            if ((state inside {LOAD, SHIFT}) && !bus.spe_i) begin
                // Abort: drop straight back to idle without completion pulses
                state    <= IDLE;
                edge_cnt <= '0;
                sclk_q   <= bus.cpol_i;
                ss_q     <= 1'b1;
                busy_q   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sclk_q   <= bus.cpol_i;
                        ss_q     <= 1'b1;
                        busy_q   <= 1'b0;
                        edge_cnt <= '0;
                        if (bus.start_i && bus.spe_i) begin
                            state  <= LOAD;
                            busy_q <= 1'b1;
                            send_q <= 1'b1;
                            cfg_q  <= '{cpol: bus.cpol_i, cpha: bus.cpha_i,
                                        sppr: bus.sppr_i, spr: bus.spr_i};
                        end
                    end
                    LOAD: begin
                        state   <= SHIFT;
                        ss_q    <= 1'b0;
                        // CPHA=0 presents the first MOSI bit at the lead-in
                        mosi_q  <= !cfg_q.cpha && pair_sclk_c;
                        mosi0_q <= !cfg_q.cpha && !pair_sclk_c;
                    end
                    SHIFT: begin
                        if (edge_q && (edge_cnt == TAIL_END)) begin
                            state  <= DONE;
                            ss_q   <= 1'b1;
                            sclk_q <= cfg_q.cpol;
                            rdv_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            if (edge_q) begin
                                sclk_q <= ~sclk_q;
                            end
                            if (half_tick_c) begin
                                edge_q   <= 1'b1;
                                edge_cnt <= next_edge_c;
                                mosi_q   <= send_hit_c && pair_sclk_c;
                                mosi0_q  <= send_hit_c && !pair_sclk_c;
                                miso_q   <= recv_hit_c && pair_sclk_c;
                                miso0_q  <= recv_hit_c && !pair_sclk_c;
                            end
                        end
                    end
                    DONE: begin
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                        ss_q     <= 1'b1;
                        sclk_q   <= bus.cpol_i;
                        edge_cnt <= '0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sclk_o               = sclk_q;
    assign bus.ss_o                 = ss_q;
    assign bus.send_data_o          = send_q;
    assign bus.recieve_data_o       = rdv_q;
    assign bus.busy_o               = busy_q;
    assign bus.done_o               = done_q;
    assign bus.mosi_send_sclk_o     = mosi_q;
    assign bus.mosi_send_sclk0_o    = mosi0_q;
    assign bus.miso_recieve_sclk_o  = miso_q;
    assign bus.miso_recieve_sclk0_o = miso0_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: scoreboard bench for spi_xfer_ctrl. Each directed transfer
// pushes a hand-computed summary; a monitor builds the observed summary over
// every busy window and compares when busy falls.
module tb_spi_xfer_ctrl;
    import spi_pkg::*;

    logic PCLK = 1'b0;
    logic PRESET;

    spi_xfer_ctrl_if bus ();

    spi_xfer_ctrl dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    initial forever #5 PCLK = ~PCLK;

    // Per-transfer summary; positions are 1-based cycles counted from busy rise
    typedef struct {
        int busy_len;
        int sd_pos;
        int ss_low;
        int tog;
        int first_tog;
        int snd_a;
        int rcv_a;
        int snd_b;
        int rcv_b;
        int snd_sclk;
        int rcv_sclk;
        int done_pos;
        int rdv_pos;
        int sclk_idle;
        int ss_idle;
    } xfer_t;

    xfer_t exp_q[$];
    int total    = 0;
    int bad      = 0;
    int n_pushed = 0;
    int n_seen   = 0;
    int stray    = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input xfer_t e);
        exp_q.push_back(e);
        n_pushed++;
    endtask

    task automatic cfg(input logic cpol, input logic cpha,
                       input logic [2:0] sppr, input logic [2:0] spr);
        @(negedge PCLK);
        bus.cpol_i = cpol;
        bus.cpha_i = cpha;
        bus.sppr_i = sppr;
        bus.spr_i  = spr;
        repeat (2) @(negedge PCLK);
    endtask

    // Returns at the negedge inside T1 (LOAD cycle)
    task automatic pulse_start;
        @(negedge PCLK);
        bus.start_i = 1'b1;
        @(negedge PCLK);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy_o !== 1'b0 && n < 3000) begin
            @(negedge PCLK);
            n++;
        end
        chk(name, int'(n < 3000), 1);
        repeat (3) @(negedge PCLK);
    endtask

    // Monitor: accumulate one summary per busy window, check on busy fall
    initial begin : monitor
        xfer_t obs;
        xfer_t e;
        bit    in_x = 1'b0;
        logic  prev_sclk = 1'b0;
        forever begin
            @(negedge PCLK);
            if (bus.busy_o === 1'b1) begin
                if (!in_x) begin
                    in_x = 1'b1;
                    obs  = '{default: 0};
                end
                obs.busy_len++;
                if (bus.send_data_o) obs.sd_pos = obs.busy_len;
                if (!bus.ss_o) obs.ss_low++;
                if (bus.sclk_o !== prev_sclk) begin
                    obs.tog++;
                    if (obs.first_tog == 0) obs.first_tog = obs.busy_len;
                end
                if (bus.mosi_send_sclk_o) begin
                    obs.snd_a++;
                    obs.snd_sclk += int'(bus.sclk_o);
                end
                if (bus.mosi_send_sclk0_o) begin
                    obs.snd_b++;
                    obs.snd_sclk += int'(bus.sclk_o);
                end
                if (bus.miso_recieve_sclk_o) begin
                    obs.rcv_a++;
                    obs.rcv_sclk += int'(bus.sclk_o);
                end
                if (bus.miso_recieve_sclk0_o) begin
                    obs.rcv_b++;
                    obs.rcv_sclk += int'(bus.sclk_o);
                end
                if (bus.done_o) obs.done_pos = obs.busy_len;
                if (bus.recieve_data_o) obs.rdv_pos = obs.busy_len;
            end else begin
                if (in_x) begin
                    in_x = 1'b0;
                    obs.sclk_idle = int'(bus.sclk_o);
                    obs.ss_idle   = int'(bus.ss_o);
                    n_seen++;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("busy_len",  obs.busy_len,  e.busy_len);
                        chk("send_pos",  obs.sd_pos,    e.sd_pos);
                        chk("ss_low",    obs.ss_low,    e.ss_low);
                        chk("sclk_togs", obs.tog,       e.tog);
                        chk("first_tog", obs.first_tog, e.first_tog);
                        chk("mosi_sclk", obs.snd_a,     e.snd_a);
                        chk("miso_sclk", obs.rcv_a,     e.rcv_a);
                        chk("mosi_sclk0", obs.snd_b,    e.snd_b);
                        chk("miso_sclk0", obs.rcv_b,    e.rcv_b);
                        chk("send_sclk_lvl", obs.snd_sclk, e.snd_sclk);
                        chk("recv_sclk_lvl", obs.rcv_sclk, e.rcv_sclk);
                        chk("done_pos",  obs.done_pos,  e.done_pos);
                        chk("rdv_pos",   obs.rdv_pos,   e.rdv_pos);
                        chk("sclk_idle", obs.sclk_idle, e.sclk_idle);
                        chk("ss_idle",   obs.ss_idle,   e.ss_idle);
                    end
                end
                if (bus.send_data_o === 1'b1 || bus.recieve_data_o === 1'b1 ||
                    bus.done_o === 1'b1 || bus.mosi_send_sclk_o === 1'b1 ||
                    bus.mosi_send_sclk0_o === 1'b1 || bus.miso_recieve_sclk_o === 1'b1 ||
                    bus.miso_recieve_sclk0_o === 1'b1) begin
                    stray++;
                end
            end
            prev_sclk = bus.sclk_o;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [3:0] strb;
        PRESET      = 1'b1;
        bus.spe_i   = 1'b0;
        bus.start_i = 1'b0;
        bus.cpol_i  = 1'b0;
        bus.cpha_i  = 1'b0;
        bus.sppr_i  = 3'd0;
        bus.spr_i   = 3'd0;
        repeat (3) @(negedge PCLK);

        // Reset values
        strb = {bus.mosi_send_sclk_o, bus.mosi_send_sclk0_o,
                bus.miso_recieve_sclk_o, bus.miso_recieve_sclk0_o};
        chk("rst_sclk",  int'(bus.sclk_o), 0);
        chk("rst_ss",    int'(bus.ss_o), 1);
        chk("rst_busy",  int'(bus.busy_o), 0);
        chk("rst_send",  int'(bus.send_data_o), 0);
        chk("rst_rdv",   int'(bus.recieve_data_o), 0);
        chk("rst_done",  int'(bus.done_o), 0);
        chk("rst_strb",  int'(strb), 0);
        PRESET    = 1'b0;
        bus.spe_i = 1'b1;

        // Mode 0, H=1
        cfg(1'b0, 1'b0, 3'd0, 3'd0);
        push(xfer_t'{20, 1, 18, 16, 4, 8, 8, 0, 0, 7, 0, 20, 20, 0, 1});
        pulse_start();
        wait_idle("timeout_mode0");

        // Mode 3, H=6
        cfg(1'b1, 1'b1, 3'd2, 3'd1);
        push(xfer_t'{105, 1, 103, 16, 9, 8, 8, 0, 0, 8, 0, 105, 105, 1, 1});
        pulse_start();
        wait_idle("timeout_mode3");

        // Mode 1, H=1
        cfg(1'b0, 1'b1, 3'd0, 3'd0);
        push(xfer_t'{20, 1, 18, 16, 4, 0, 0, 8, 8, 0, 8, 20, 20, 0, 1});
        pulse_start();
        wait_idle("timeout_mode1");

        // Mode 2, H=1
        cfg(1'b1, 1'b0, 3'd0, 3'd0);
        push(xfer_t'{20, 1, 18, 16, 4, 0, 0, 8, 8, 1, 8, 20, 20, 1, 1});
        pulse_start();
        wait_idle("timeout_mode2");

        // spe dropped after edge 5 (mode 0, H=2): spe low sampled at end of T13
        cfg(1'b0, 1'b0, 3'd1, 3'd0);
        push(xfer_t'{13, 1, 12, 5, 5, 3, 3, 0, 0, 2, 0, 0, 0, 0, 1});
        pulse_start();
        repeat (12) @(negedge PCLK);
        bus.spe_i = 1'b0;
        @(negedge PCLK);
        bus.spe_i = 1'b1;
        wait_idle("timeout_abort");

        // Full transfer after the abort (mode 0, H=1)
        cfg(1'b0, 1'b0, 3'd0, 3'd0);
        push(xfer_t'{20, 1, 18, 16, 4, 8, 8, 0, 0, 7, 0, 20, 20, 0, 1});
        pulse_start();
        wait_idle("timeout_after_abort");

        // Mode 1, H=2 with start pulse and config change mid-SHIFT
        cfg(1'b0, 1'b1, 3'd1, 3'd0);
        push(xfer_t'{37, 1, 35, 16, 5, 0, 0, 8, 8, 0, 8, 37, 37, 0, 1});
        pulse_start();
        repeat (7) @(negedge PCLK);
        bus.start_i = 1'b1;
        bus.cpol_i  = 1'b1;
        bus.cpha_i  = 1'b0;
        bus.sppr_i  = 3'd7;
        bus.spr_i   = 3'd7;
        @(negedge PCLK);
        bus.start_i = 1'b0;
        repeat (11) @(negedge PCLK);
        bus.cpol_i  = 1'b0;
        bus.cpha_i  = 1'b1;
        bus.sppr_i  = 3'd1;
        bus.spr_i   = 3'd0;
        wait_idle("timeout_midshift");

        // PRESET during SHIFT (mode 3, H=1), asserted in T6
        cfg(1'b1, 1'b1, 3'd0, 3'd0);
        push(xfer_t'{6, 1, 5, 3, 4, 2, 2, 0, 0, 2, 0, 0, 0, 0, 1});
        pulse_start();
        repeat (5) @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        strb = {bus.mosi_send_sclk_o, bus.mosi_send_sclk0_o,
                bus.miso_recieve_sclk_o, bus.miso_recieve_sclk0_o};
        chk("prst_strb", int'(strb), 0);
        chk("prst_busy", int'(bus.busy_o), 0);
        PRESET = 1'b0;
        wait_idle("timeout_preset");

        // start_i together with spe_i falling: no transfer
        @(negedge PCLK);
        bus.start_i = 1'b1;
        bus.spe_i   = 1'b0;
        @(negedge PCLK);
        bus.start_i = 1'b0;
        chk("nostart_busy", int'(bus.busy_o), 0);
        repeat (4) @(negedge PCLK);
        bus.spe_i = 1'b1;
        repeat (4) @(negedge PCLK);

        chk("xfer_count",     n_seen, n_pushed);
        chk("stray_pulses",   stray, 0);
        chk("exp_queue_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
